// File: rtl/fft_mux_ctrl.sv
// fft_mux_ctrl: frame sequencer for the external/feedback mux ahead of the FFT butterflies.
// Optional abort input is compiled in when FFT_MUX_CTRL_ABORT_EN is defined.
module fft_mux_ctrl #(
  parameter int LOAD_BEATS      = 4,
  parameter int STAGES          = 5,
  parameter int BEATS_PER_STAGE = 4,
  parameter int GAP             = 2,
  localparam int LB_MAX   = (LOAD_BEATS > BEATS_PER_STAGE) ? LOAD_BEATS : BEATS_PER_STAGE,
  localparam int LG_MAX   = (LB_MAX > GAP) ? LB_MAX : GAP,
  localparam int BEAT_MAX = (LG_MAX > 2) ? LG_MAX : 2,
  localparam int SW       = $clog2(STAGES + 1),
  localparam int BW       = $clog2(BEAT_MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef FFT_MUX_CTRL_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  input  logic          fb_valid,
  output logic          mux_flag,
  output logic          sel_valid,
  output logic [SW-1:0] stage_idx,
  output logic [BW-1:0] beat_idx,
  output logic          busy,
  output logic          done,
  output logic          protocol_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GAP, S_CALC, S_DONE} state_t;

  localparam logic [BW-1:0] LOAD_LAST = BW'(LOAD_BEATS - 1);
  localparam logic [BW-1:0] CALC_LAST = BW'(BEATS_PER_STAGE - 1);
  localparam logic [BW-1:0] GAP_LAST  = (GAP > 0) ? BW'(GAP - 1) : '0;
  localparam logic [SW-1:0] STG_LAST  = SW'(STAGES - 1);
  localparam state_t        PASS_ENTRY = (GAP == 0) ? S_CALC : S_GAP;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          mux_q, mux_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      stage_q <= '0;
      mux_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      stage_q <= stage_d;
      mux_q   <= mux_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    stage_d = stage_q;
    mux_d   = mux_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        mux_d = 1'b1;
        if (start) begin
          state_d = S_LOAD;
          beat_d  = '0;
          stage_d = '0;
          err_d   = 1'b0;
        end else if (fb_valid) begin
          err_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (fb_valid) err_d = 1'b1;
        if (in_valid) begin
          if (beat_q == LOAD_LAST) begin
            beat_d  = '0;
            stage_d = '0;
            mux_d   = 1'b0;
            state_d = PASS_ENTRY;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (in_valid || fb_valid) err_d = 1'b1;
        // The gap runs on time alone; valids cannot stretch or shorten it.
        if (beat_q == GAP_LAST) begin
          beat_d  = '0;
          state_d = S_CALC;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_CALC: begin
        if (in_valid) err_d = 1'b1;
        if (fb_valid) begin
          if (beat_q == CALC_LAST) begin
            beat_d = '0;
            if (stage_q == STG_LAST) begin
              state_d = S_DONE;
              mux_d   = 1'b1;
            end else begin
              stage_d = stage_q + 1'b1;
              state_d = PASS_ENTRY;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        mux_d   = 1'b1;
        beat_d  = '0;
        stage_d = '0;
        if (start) begin
          state_d = S_LOAD;
          err_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
          if (in_valid || fb_valid) err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef FFT_MUX_CTRL_ABORT_EN
    // Abort outranks start and valids; the error flag survives it.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      beat_d  = '0;
      stage_d = '0;
      mux_d   = 1'b1;
      err_d   = err_q;
    end
`endif
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    sel_valid = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        busy      = 1'b1;
        sel_valid = in_valid;
      end
      S_GAP:  busy = 1'b1;
      S_CALC: begin
        busy      = 1'b1;
        sel_valid = fb_valid;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign mux_flag     = mux_q;
  assign stage_idx    = stage_q;
  assign beat_idx     = beat_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_fft_mux_ctrl.sv
// Directed bench for fft_mux_ctrl (default parameters); abort sequence runs when
// FFT_MUX_CTRL_ABORT_EN is defined.
module tb_fft_mux_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       fb_valid = 1'b0;
  logic       mux_flag, sel_valid, busy, done, protocol_err;
  logic [2:0] stage_idx;
  logic [1:0] beat_idx;

  int n_chk  = 0;
  int n_fail = 0;

  fft_mux_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef FFT_MUX_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .in_valid     (in_valid),
    .fb_valid     (fb_valid),
    .mux_flag     (mux_flag),
    .sel_valid    (sel_valid),
    .stage_idx    (stage_idx),
    .beat_idx     (beat_idx),
    .busy         (busy),
    .done         (done),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, iv, fv;
    logic e_sel, e_mux, e_busy, e_done;
    int   e_stage, e_beat;
    logic e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; fb_valid = 1'b0; abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic exp_err);
    chk({tag, " mux_flag"}, 32'(mux_flag), 1);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " stage_idx"}, 32'(stage_idx), 0);
    chk({tag, " beat_idx"}, 32'(beat_idx), 0);
    chk({tag, " protocol_err"}, 32'(protocol_err), 32'(exp_err));
  endtask

  function automatic logic fv_base(int k);
    return (k >= 7 && k <= 34 && ((k - 7) % 6) < 4);
  endfunction

  // Optional 3-cycle fb_valid bubble after the second beat of stage 2.
  function automatic logic fv_at(int k, bit bub);
    if (!bub || k < 21) return fv_base(k);
    if (k <= 23) return 1'b0;
    return fv_base(k - 3);
  endfunction

  task automatic begin_frame(input string tag);
    start = 1'b1; in_valid = 1'b0; fb_valid = 1'b0;
    tick();
    start = 1'b0;
    chk({tag, " busy after start"}, 32'(busy), 1);
    chk({tag, " mux_flag in load"}, 32'(mux_flag), 1);
  endtask

  // Cycle 0 is the start cycle; iteration k drives cycle k, then observes cycle k+1.
  task automatic run_frame(input string tag, input bit bub, input int kmax, output int done_cyc);
    done_cyc = -1;
    for (int k = 1; k <= kmax; k++) begin
      in_valid = (k <= 4);
      fb_valid = fv_at(k, bub);
      #1;
      if (k == 2) chk($sformatf("%s sel_valid load k=%0d", tag, k), 32'(sel_valid), 1);
      if (k == 8) chk($sformatf("%s sel_valid calc k=%0d", tag, k), 32'(sel_valid), 1);
      tick();
      if (k == 3) chk({tag, " mux_flag before last load"}, 32'(mux_flag), 1);
      if (k == 4) chk({tag, " mux_flag after load"}, 32'(mux_flag), 0);
      if (!bub && (k + 1) >= 7 && (k + 1) <= 31 && ((k + 1 - 7) % 6) == 0)
        chk($sformatf("%s stage_idx cycle %0d", tag, k + 1), 32'(stage_idx), 32'((k + 1 - 7) / 6));
      if (bub && (k == 21 || k == 23)) begin
        chk($sformatf("%s bubble beat_idx cycle %0d", tag, k + 1), 32'(beat_idx), 2);
        chk($sformatf("%s bubble stage_idx cycle %0d", tag, k + 1), 32'(stage_idx), 2);
      end
      if (done) begin
        done_cyc = k + 1;
        break;
      end
    end
    in_valid = 1'b0;
    fb_valid = 1'b0;
  endtask

  task automatic count_done(input string tag, input int cycles);
    int nd = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) nd++;
    end
    chk({tag, " done pulses"}, 32'(nd), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int dc2;

    //        st iv fv  sel mux busy done stage beat err
    tbl.push_back('{0, 0, 1,  0, 1, 0, 0, 0, 0, 1});  // stray fb in IDLE
    tbl.push_back('{0, 1, 0,  0, 1, 0, 0, 0, 0, 1});  // in_valid in IDLE is harmless
    tbl.push_back('{1, 0, 0,  0, 1, 1, 0, 0, 0, 0});  // start clears err
    tbl.push_back('{0, 1, 0,  1, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0,  0, 1, 1, 0, 0, 1, 0});  // start while busy ignored
    tbl.push_back('{0, 0, 1,  0, 1, 1, 0, 0, 1, 1});  // stray fb on load beat 1
    tbl.push_back('{0, 0, 0,  0, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 0,  1, 1, 1, 0, 0, 2, 1});
    tbl.push_back('{0, 1, 0,  1, 1, 1, 0, 0, 3, 1});
    tbl.push_back('{0, 1, 1,  1, 0, 1, 0, 0, 0, 1});  // last load beat -> GAP
    tbl.push_back('{0, 0, 0,  0, 0, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 1, 0,  0, 0, 1, 0, 0, 0, 1});  // gap ends -> CALC
    tbl.push_back('{0, 0, 1,  1, 0, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 0,  0, 0, 1, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 1,  1, 0, 1, 0, 0, 2, 1});
    tbl.push_back('{0, 0, 1,  1, 0, 1, 0, 0, 3, 1});
    tbl.push_back('{0, 0, 1,  1, 0, 1, 0, 1, 0, 1});  // pass 0 done -> GAP, stage 1
    tbl.push_back('{0, 0, 0,  0, 0, 1, 0, 1, 1, 1});
    tbl.push_back('{0, 1, 1,  0, 0, 1, 0, 1, 0, 1});  // gap ends, strays ignored

    do_reset();
    chk_idle("reset", 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; in_valid = tbl[i].iv; fb_valid = tbl[i].fv;
      #1;
      chk($sformatf("vec%0d sel_valid", i), 32'(sel_valid), 32'(tbl[i].e_sel));
      tick();
      chk($sformatf("vec%0d mux_flag", i), 32'(mux_flag), 32'(tbl[i].e_mux));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d stage_idx", i), 32'(stage_idx), 32'(tbl[i].e_stage));
      chk($sformatf("vec%0d beat_idx", i), 32'(beat_idx), 32'(tbl[i].e_beat));
      chk($sformatf("vec%0d protocol_err", i), 32'(protocol_err), 32'(tbl[i].e_err));
      $display("vec%0d st=%0d iv=%0d fv=%0d -> mux=%0d busy=%0d stage=%0d beat=%0d err=%0d",
               i, tbl[i].st, tbl[i].iv, tbl[i].fv, mux_flag, busy, stage_idx, beat_idx, protocol_err);
    end
    start = 1'b0; in_valid = 1'b0; fb_valid = 1'b0;

    // Ideal frame
    do_reset();
    begin_frame("ideal");
    run_frame("ideal", 1'b0, 60, dc);
    chk("ideal done latency", 32'(dc), 35);
    chk("ideal stage_idx in done", 32'(stage_idx), 4);
    chk("ideal protocol_err", 32'(protocol_err), 0);
    tick();
    chk_idle("ideal after done", 1'b0);
    $display("ideal frame: done at cycle %0d", dc);

    // fb_valid bubble in stage 2
    begin_frame("bubble");
    run_frame("bubble", 1'b1, 60, dc);
    chk("bubble done latency", 32'(dc), 38);
    tick();
    chk("bubble done width", 32'(done), 0);
    $display("bubble frame: done at cycle %0d", dc);

    // Back-to-back frames
    begin_frame("b2b1");
    run_frame("b2b1", 1'b0, 60, dc);
    chk("b2b first done latency", 32'(dc), 35);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy after done", 32'(busy), 1);
    chk("b2b mux_flag after done", 32'(mux_flag), 1);
    chk("b2b done single", 32'(done), 0);
    chk("b2b beat_idx", 32'(beat_idx), 0);
    chk("b2b stage_idx", 32'(stage_idx), 0);
    run_frame("b2b2", 1'b0, 60, dc2);
    chk("b2b second done latency", 32'(dc2), 35);
    tick();
    chk("b2b final done width", 32'(done), 0);
    chk("b2b final busy", 32'(busy), 0);
    $display("back-to-back: done at cycles %0d and %0d", dc, dc2);

    // Reset mid-CALC in stage 3, after a stray in_valid
    begin_frame("rstcalc");
    run_frame("rstcalc", 1'b0, 25, dc);
    chk("rstcalc no early done", 32'(dc), 32'(-1));
    chk("rstcalc stage_idx", 32'(stage_idx), 3);
    chk("rstcalc beat_idx", 32'(beat_idx), 1);
    in_valid = 1'b1;
    #1;
    chk("rstcalc stray sel_valid", 32'(sel_valid), 0);
    tick();
    in_valid = 1'b0;
    chk("rstcalc stray err", 32'(protocol_err), 1);
    chk("rstcalc stray beat hold", 32'(beat_idx), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rstcalc after rst", 1'b0);
    count_done("rstcalc", 40);
    $display("reset mid-calc: returned to idle");

`ifdef FFT_MUX_CTRL_ABORT_EN
    begin_frame("abort");
    run_frame("abort", 1'b0, 25, dc);
    chk("abort stage_idx", 32'(stage_idx), 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("abort stray err", 32'(protocol_err), 1);
    abort = 1'b1; start = 1'b1; fb_valid = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0; fb_valid = 1'b0;
    chk_idle("abort after abort", 1'b1);
    count_done("abort", 40);
    $display("abort mid-calc: returned to idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
